// File: rtl/eval_sequencer_pkg.sv
// Shared definitions for the evaluation kernel sequencer: FSM encoding, the kernel
// latency default shared with the kernel top, and operand generation helpers.
package eval_sequencer_pkg;

  localparam int unsigned KernelLat = 2;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  function automatic logic [7:0] gen_op_a(input logic [7:0] seed, input logic [7:0] idx);
    return seed + idx;
  endfunction

  function automatic logic [7:0] gen_op_b(input logic [7:0] seed, input logic [7:0] idx);
    return seed - idx;
  endfunction

endpackage

// File: rtl/eval_sequencer_if.sv
// Kernel operand/result bus plus the downstream result valid/ready stream.
interface eval_sequencer_if #(
  parameter int unsigned IDX_W = 8
) ();

  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             op_mode;
  logic [7:0]       kres;
  logic [7:0]       res_data;
  logic [IDX_W-1:0] res_idx;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output op_a,
    output op_b,
    output op_mode,
    output res_data,
    output res_idx,
    output res_valid,
    input  kres,
    input  res_ready
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  op_mode,
    input  res_data,
    input  res_idx,
    input  res_valid,
    output kres,
    output res_ready
  );

endinterface

// File: rtl/eval_sequencer_result_fifo.sv
// First-word-fall-through result FIFO; DEPTH must be a power of two so pointers wrap freely.
module eval_sequencer_result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/eval_sequencer.sv
// Issues generated operand pairs to the evaluation kernel, tracks them through its fixed
// latency with a tag pipeline and buffers the tagged results for a downstream consumer.
module eval_sequencer import eval_sequencer_pkg::*; #(
  parameter int unsigned KERNEL_LAT = KernelLat,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_ops,
  input  logic [7:0]       seed_a,
  input  logic [7:0]       seed_b,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  eval_sequencer_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LW = $clog2(KERNEL_LAT + 1);
  localparam int unsigned FW = IDX_W + 8;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      last_q;
  logic [7:0]            seed_a_q, seed_b_q;
  logic                  mode_q;
  logic [7:0]            op_a_q, op_b_q;
  logic                  op_mode_q;
  logic                  busy_q, done_q;
  logic                  issue, credit;
  logic [7:0]            idx8;

  logic [KERNEL_LAT-1:0] tag_vld_q;
  logic [IDX_W-1:0]      tag_idx_q [KERNEL_LAT];
  logic [LW-1:0]         in_flight;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_head;
  logic [CW-1:0]         fifo_count;

  assign idx8 = 8'(idx_q);

  always_comb begin
    in_flight = '0;
    for (int k = 0; k < KERNEL_LAT; k++) begin
      in_flight = in_flight + LW'(tag_vld_q[k]);
    end
  end

  // Reserve a FIFO slot for every op in flight so a captured result always has room.
  assign credit = (32'(fifo_count) + 32'(in_flight) + 32'd1) <= FIFO_DEPTH;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          state_d = (num_ops == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (credit) begin
          issue = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == last_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (in_flight == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      last_q    <= '0;
      seed_a_q  <= '0;
      seed_b_q  <= '0;
      mode_q    <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_mode_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == StIssue) || (state_d == StDrain);
      done_q  <= (state_d == StDone);
      if ((state_q == StIdle) && start) begin
        last_q   <= num_ops - IDX_W'(1);
        seed_a_q <= seed_a;
        seed_b_q <= seed_b;
        mode_q   <= mode;
      end
      // Operands only move on an issue so the kernel inputs stay steady otherwise.
      if (issue) begin
        op_a_q    <= gen_op_a(seed_a_q, idx8);
        op_b_q    <= gen_op_b(seed_b_q, idx8);
        op_mode_q <= mode_q;
      end
    end
  end

  // Tag pipeline: shifts every cycle, a bubble is entered when nothing is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int k = 0; k < KERNEL_LAT; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      tag_vld_q[0] <= issue;
      tag_idx_q[0] <= idx_q;
      for (int k = 1; k < KERNEL_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
    end
  end

  assign fifo_push = tag_vld_q[KERNEL_LAT-1];
  assign fifo_pop  = !fifo_empty && bus.res_ready;

  eval_sequencer_result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({tag_idx_q[KERNEL_LAT-1], bus.kres}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_full && fifo_push && !fifo_pop));
    end
  end

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_mode   = op_mode_q;
  assign bus.res_data  = fifo_head[7:0];
  assign bus.res_idx   = fifo_head[FW-1:8];
  assign bus.res_valid = !fifo_empty;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_eval_sequencer.sv
// Bench for eval_sequencer: a registered kernel stub plus a per-run list of expected
// tagged results computed directly from the operand and kernel arithmetic.
module tb_eval_sequencer;
  import eval_sequencer_pkg::*;

  localparam int unsigned KLAT  = KernelLat;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [IW-1:0] num_ops = '0;
  logic [7:0]    seed_a = '0;
  logic [7:0]    seed_b = '0;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  eval_sequencer_if #(.IDX_W(IW)) bus ();

  eval_sequencer #(
    .KERNEL_LAT (KLAT),
    .FIFO_DEPTH (DEPTH),
    .IDX_W      (IW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .num_ops (num_ops),
    .seed_a  (seed_a),
    .seed_b  (seed_b),
    .mode    (mode),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] kfun(input logic [7:0] a, input logic [7:0] b, input logic m);
    return m ? (a ^ b) : 8'(a + ~b);
  endfunction

  // Kernel stub: result register updates KERNEL_LAT cycles after the issue decision.
  logic [7:0] kpipe [KLAT-1];
  always @(posedge clk) begin
    kpipe[0] <= kfun(bus.op_a, bus.op_b, bus.op_mode);
    for (int k = 1; k < KLAT - 1; k++) kpipe[k] <= kpipe[k-1];
  end
  assign bus.kres = kpipe[KLAT-2];

  logic [IW+7:0] got_q[$];
  logic [IW+7:0] exp_q[$];
  logic [15:0]   ops_q[$];
  logic [15:0]   prev_pair = '0;
  int            done_cnt = 0;
  int            issue_cnt = 0;

  always @(negedge clk) begin
    if ({bus.op_a, bus.op_b} != prev_pair) begin
      ops_q.push_back({bus.op_a, bus.op_b});
      issue_cnt++;
    end
    prev_pair = {bus.op_a, bus.op_b};
    if (!rst) begin
      if (bus.res_valid && bus.res_ready) got_q.push_back({bus.res_idx, bus.res_data});
      if (done) done_cnt++;
    end
  end

  function automatic void build_exp(input int n, input logic [7:0] sa, input logic [7:0] sb,
                                    input logic m);
    logic [7:0] a, b;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = sa + 8'(i);
      b = sb - 8'(i);
      exp_q.push_back({IW'(i), kfun(a, b, m)});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    ops_q.delete();
    done_cnt  = 0;
    issue_cnt = 0;
  endtask

  task automatic start_run(input int n, input logic [7:0] sa, input logic [7:0] sb,
                           input logic m);
    num_ops = IW'(n);
    seed_a  = sa;
    seed_b  = sb;
    mode    = m;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < limit) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    tick();
  endtask

  task automatic wait_results(input int n, input int limit);
    int c = 0;
    while (got_q.size() < n && c < limit) begin
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (bus.op_a !== 8'h00) begin errors++; $display("FAIL reset_op_a: got %h want 00", bus.op_a); end
    checks++;
    if (bus.op_b !== 8'h00) begin errors++; $display("FAIL reset_op_b: got %h want 00", bus.op_b); end
    checks++;
    if (bus.op_mode !== 1'b0) begin
      errors++; $display("FAIL reset_op_mode: got %b want 0", bus.op_mode);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mode0();
    int lat;
    bit seen;
    logic [IW+7:0] first;
    clear_obs();
    build_exp(4, 8'h10, 8'h20, 1'b0);
    start_run(4, 8'h10, 8'h20, 1'b0);
    wait_done(40, lat, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL mode0_done: got no done want pulse"); end
    wait_results(4, 20);
    repeat (4) tick();
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL mode0_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mode0_res[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x,
                 exp_q[i]);
      end
    end
    first = (got_q.size() > 0) ? got_q[0] : '1;
    checks++;
    if (first !== {8'h00, 8'hEF}) begin
      errors++; $display("FAIL mode0_first: got %h want 00ef", first);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL mode0_done_once: got %0d want 1", done_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mode0_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_wrap();
    int lat;
    bit seen;
    logic [15:0] want_ops [3] = '{16'hFE01, 16'hFF00, 16'h00FF};
    clear_obs();
    build_exp(3, 8'hFE, 8'h01, 1'b1);
    start_run(3, 8'hFE, 8'h01, 1'b1);
    wait_done(40, lat, seen);
    wait_results(3, 20);
    checks++;
    if (ops_q.size() != 3) begin
      errors++; $display("FAIL wrap_issue_count: got %0d want 3", ops_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ops_q.size() || ops_q[i] !== want_ops[i]) begin
        errors++;
        $display("FAIL wrap_ops[%0d]: got %h want %h", i, (i < ops_q.size()) ? ops_q[i] : 'x,
                 want_ops[i]);
      end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_res[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x,
                 exp_q[i]);
      end
    end
  endtask

  task automatic test_zero();
    int lat;
    bit seen;
    clear_obs();
    start_run(0, 8'h5A, 8'hA5, 1'b0);
    wait_done(10, lat, seen);
    checks++;
    if (!seen || lat > 2) begin
      errors++; $display("FAIL zero_done_latency: got seen=%0d lat=%0d want seen=1 lat<=2", seen, lat);
    end
    repeat (10) tick();
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL zero_results: got %0d want 0", got_q.size());
    end
    checks++;
    if (done_cnt != 1 || issue_cnt != 0) begin
      errors++;
      $display("FAIL zero_pulse: got done=%0d issues=%0d want 1 and 0", done_cnt, issue_cnt);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit seen;
    logic [7:0] sa, sb;
    logic m;
    sa = 8'($urandom_range(1, 240));
    sb = 8'($urandom);
    m  = 1'($urandom);
    bus.res_ready = 1'b0;
    clear_obs();
    build_exp(10, sa, sb, m);
    start_run(10, sa, sb, m);
    repeat (30) tick();
    @(negedge clk);
    checks++;
    if (issue_cnt != DEPTH) begin
      errors++; $display("FAIL bp_stall_issues: got %0d want %0d", issue_cnt, DEPTH);
    end
    checks++;
    if (busy !== 1'b1 || bus.res_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stalled: got busy=%b valid=%b want 1 1", busy, bus.res_valid);
    end
    checks++;
    if ({bus.res_idx, bus.res_data} !== exp_q[0]) begin
      errors++; $display("FAIL bp_head: got %h want %h", {bus.res_idx, bus.res_data}, exp_q[0]);
    end
    tick();
    // A start while busy must not disturb the run in progress.
    num_ops = IW'(3);
    seed_a  = ~sa;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    bus.res_ready = 1'b1;
    wait_done(100, lat, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_done: got no done want pulse"); end
    wait_results(10, 40);
    repeat (6) tick();
    checks++;
    if (got_q.size() != 10) begin
      errors++; $display("FAIL bp_count: got %0d want 10", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_res[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x,
                 exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL bp_done_once: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    int n, cyc;
    logic [7:0] sa, sb;
    logic m;
    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(1, 20);
      sa = 8'($urandom);
      sb = 8'($urandom);
      m  = 1'($urandom);
      clear_obs();
      build_exp(n, sa, sb, m);
      start_run(n, sa, sb, m);
      cyc = 0;
      while ((done_cnt == 0 || got_q.size() < n) && cyc < 600) begin
        bus.res_ready = 1'($urandom);
        tick();
        cyc++;
      end
      bus.res_ready = 1'b1;
      repeat (6) tick();
      checks++;
      if (got_q.size() != n || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d results %0d dones want %0d and 1", r, got_q.size(),
                 done_cnt, n);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_res[%0d]: got %h want %h", r, i,
                   (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_midreset();
    int lat;
    bit seen;
    bus.res_ready = 1'b1;
    clear_obs();
    start_run(10, 8'h33, 8'h44, 1'b0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got valid=%b busy=%b done=%b want 0 0 0", bus.res_valid, busy,
               done);
    end
    tick();
    clear_obs();
    build_exp(2, 8'h55, 8'h66, 1'b1);
    start_run(2, 8'h55, 8'h66, 1'b1);
    wait_done(40, lat, seen);
    wait_results(2, 20);
    repeat (10) tick();
    checks++;
    if (!seen || got_q.size() != 2) begin
      errors++; $display("FAIL midrst_count: got seen=%0d n=%0d want 1 and 2", seen, got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_res[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x,
                 exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.res_ready = 1'b1;
    test_reset();
    test_mode0();
    test_wrap();
    test_zero();
    test_backpressure();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eval_sequencer.md
Name: eval_sequencer

Overview:
- Initiator side of the evaluation kernel interface. Generates operand pairs and a mode bit, and issues them to the kernel's data_in1/data_in2/kernel_enable inputs.
- Tracks each issued operation through the kernel's fixed pipeline latency. Captures the matching kernel result into a small output FIFO.
- Presents captured results downstream with a valid/ready handshake, tagged by operation index.
- Sits between the test/control logic and the kernel in the FPGA top level.

Parameters:
- KERNEL_LAT, 2, cycles from operand issue to the matching kernel result register update.
- FIFO_DEPTH, 4, result FIFO entries; must be a power of 2 and at least 2.
- IDX_W, 8, width of the operation count and index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when IDLE, ignored otherwise.
- num_ops  in  IDX_W  operations per run, sampled at start; 0 means an immediately completed run.
- seed_a  in  8  operand A base, sampled at start.
- seed_b  in  8  operand B base, sampled at start.
- mode  in  1  kernel_enable value for the run, sampled at start.
- op_a  out  8  to kernel data_in1.
- op_b  out  8  to kernel data_in2.
- op_mode  out  1  to kernel kernel_enable.
- kres  in  8  from kernel result.
- res_data  out  8  FIFO head result.
- res_idx  out  IDX_W  operation index of the FIFO head.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  downstream accepts the head.
- busy  out  1  high in ISSUE or DRAIN.
- done  out  1  one-cycle pulse on entering DONE.

Behaviour:
- Reset: state IDLE; op_a, op_b, op_mode, busy and done are 0; FIFO empty, so res_valid is 0. The tag pipeline is cleared. All outputs are registered.
- Operand generation: for index i, op_a = seed_a + i and op_b = seed_b - i, both mod 256. Wrap-around is silent.
- op_a, op_b and op_mode hold their last issued values when not issuing, so kernel inputs never glitch.
- States and transitions:
  - IDLE: on start, latch the run inputs and set i=0. If num_ops == 0, go to DONE; otherwise go to ISSUE.
  - ISSUE: issue one op per cycle when credit is available. After issuing index num_ops-1, go to DRAIN.
  - DRAIN: wait until the tag pipeline is empty, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE. The FIFO is not flushed, so results may still be pending at that point.
- Tag pipeline: a KERNEL_LAT-deep shift register of {valid, idx}. An entry is pushed when an op is driven onto op_*. When an entry reaches the tail with valid set, kres is pushed into the FIFO with that idx in the same cycle.
- Credit rule: issue only if fifo_count + in_flight + 1 <= FIFO_DEPTH, where in_flight counts valid tags. When no credit is available, a bubble (invalid tag) is inserted. This guarantees the FIFO never overflows and no result is ever dropped.
- FIFO:
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pop occurs on res_valid && res_ready.
  - Pop from empty never happens because res_valid gates it.
  - First-word-fall-through: res_data and res_idx are valid whenever res_valid is high.
- start while busy or in DONE is ignored.
- Reset mid-run: rst dominates. All in-flight tags and FIFO contents are discarded, and the block returns to IDLE the next cycle.
- Counter widths: the index counter is IDX_W bits, and num_ops up to 2^IDX_W-1 is supported.

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, DRAIN, DONE) and the default KERNEL_LAT constant, which is shared with the kernel top.
- One natural sub-module: result_fifo, parameterised by width and depth, with push/pop/count/full/empty.
- Tag pipeline and FSM live in eval_sequencer.

Test Plan:
1. Reset with rst=1 for 3 cycles -> res_valid=0, busy=0, done=0, op_a=op_b=0, op_mode=0.
2. Mode-0 run with res_ready=1: start, num_ops=4, seed_a=0x10, seed_b=0x20, mode=0, kernel model = a + ~b -> results 0x10+0xDF=0xEF, 0x11+0xE0=0xF1, 0xF3, 0xF5 with idx 0..3 in order; done pulses once, 4 cycles after the last issue plus DRAIN.
3. Backpressure: res_ready=0, num_ops=10 -> exactly 4 results buffered, issue stalls with no op lost. Then res_ready=1 -> all 10 delivered, idx 0..9 contiguous, no duplicates.
4. Wrap-around: seed_a=0xFE, seed_b=0x01, num_ops=3 -> op_a issued 0xFE, 0xFF, 0x00 and op_b issued 0x01, 0x00, 0xFF.
5. num_ops=0 -> done pulses 2 cycles after start, and no result is produced.
6. Reset mid-run: assert rst in the middle of a 10-op run -> next cycle res_valid=0 and state IDLE; a following start with num_ops=2 delivers only idx 0, 1.
